// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake, optional two-entry skid
// buffer, synchronous flush, bubble insertion and a saturating stall counter.
module pipe_skid_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CTRL_W = 18,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              bubble,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } word_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   word_t            m_q, m_d, s_q, s_d, in_word;
   logic             mv_q, mv_d, sv_q, sv_d;
   logic             rdy_q, rdy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, drain;

   // in_ready: skid variant comes straight from a flop; flow-through variant
   // lets a downstream drain free the single slot in the same cycle.
   if (SKID != 0) begin : g_skid_ready
      assign in_ready = rdy_q;
   end else begin : g_flow_ready
      assign in_ready = rdy_q & (~mv_q | out_ready);
   end

   assign out_valid = mv_q;
   assign out_data  = m_q.data;
   assign out_ctrl  = m_q.ctrl;
   assign occupancy = {1'b0, mv_q} + {1'b0, sv_q};
   assign stall_cnt = cnt_q;

   // Next-state for the main/skid entries, ready flop and stall counter.
   always_comb begin
      mv_d   = mv_q;
      sv_d   = sv_q;
      m_d    = m_q;
      s_d    = s_q;
      cnt_d  = cnt_q;
      accept = in_valid & in_ready;
      drain  = mv_q & out_ready;

      in_word.data = in_data;
      in_word.ctrl = bubble ? '0 : in_ctrl;

      if (flush) begin
         mv_d = 1'b0;
         sv_d = 1'b0;
         m_d  = '0;
         s_d  = '0;
      end else if (SKID != 0) begin
         if (!mv_q) begin
            if (accept) begin
               m_d  = in_word;
               mv_d = 1'b1;
            end
         end else if (sv_q) begin
            // in_ready is low here, so only the S->M move can happen
            if (drain) begin
               m_d  = s_q;
               sv_d = 1'b0;
            end
         end else if (drain) begin
            if (accept) m_d = in_word;
            else        mv_d = 1'b0;
         end else if (accept) begin
            s_d  = in_word;
            sv_d = 1'b1;
         end
      end else begin
         if (accept) begin
            m_d  = in_word;
            mv_d = 1'b1;
         end else if (drain) begin
            mv_d = 1'b0;
         end
      end

      if (SKID == 0) begin
         sv_d = 1'b0;
         s_d  = '0;
      end

      rdy_d = (SKID != 0) ? ~sv_d : 1'b1;

      if (mv_q && !out_ready && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
   end

   // State registers; reset drops all held words and blocks input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mv_q  <= 1'b0;
         sv_q  <= 1'b0;
         m_q   <= '0;
         s_q   <= '0;
         rdy_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         mv_q  <= mv_d;
         sv_q  <= sv_d;
         m_q   <= m_d;
         s_q   <= s_d;
         rdy_q <= rdy_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage for the 16-bit pipelined CPU. It replaces the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that carries a data bundle and a control bundle, and adds four things: a valid/ready handshake, an optional two-entry skid buffer, synchronous flush, and bubble insertion (control forced to zero). It sits between any two pipeline stages. It also exposes occupancy and a saturating stall counter for performance debug.

## Interface
- DATA_W, 16, width of the data bundle (PC, operands, immediates).
- CTRL_W, 18, width of the control bundle (same bit layout as the decoder's control word).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 8, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a word.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- bubble  in  1  capture zero control for the word accepted this cycle.
- flush  in  1  discard all held words at the next edge.
- out_valid  out  1  stage presents a word.
- out_ready  in  1  downstream accepts the presented word.
- out_data  out  DATA_W  presented data bundle.
- out_ctrl  out  CTRL_W  presented control bundle.
- occupancy  out  2  number of words held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- State: main entry M (mv, m_data, m_ctrl) and skid entry S (sv, s_data, s_ctrl). S exists only when SKID=1.
- Handshake signals:
  - Accept = in_valid && in_ready.
  - Drain = mv && out_ready.
- Outputs: out_valid = mv; out_data/out_ctrl = M contents.
- in_ready:
  - SKID=1: in_ready = !sv.
  - SKID=0: in_ready = !mv || out_ready.
  - Forced 0 while rst is low.
- Captured control = bubble ? 0 : in_ctrl. Data is always captured as presented.
- Update rules when flush=0 (SKID=1):
  - mv=0, Accept: input goes to M.
  - mv=1, Drain, sv=0, Accept: input goes to M.
  - mv=1, Drain, sv=0, no Accept: mv clears.
  - mv=1, no Drain, sv=0, Accept: input goes to S; sv=1.
  - mv=1, Drain, sv=1: S moves to M; sv clears. No Accept is possible in this case because in_ready=0.
  - mv=1, no Drain, sv=1: hold.
- SKID=0: only M exists. On Accept, the input goes to M (including in the Drain cycle). On Drain without Accept, mv clears.
- Flush:
  - flush=1 has priority over every rule above. At the next edge mv=sv=0.
  - A word accepted in the flush cycle is discarded.
  - A Drain in the flush cycle still counts as delivered downstream.
  - Data and control registers are also cleared to 0.
- Ordering is strict FIFO. A word in S is never presented before the word in M.
- occupancy = mv + sv.
- stall_cnt increments by 1 each cycle that out_valid && !out_ready. It holds at 2^CNT_W−1 and is not cleared by flush.

## Timing
- Reset values (asynchronous, while rst is low):
  - mv=sv=0.
  - out_valid=0, out_data=0, out_ctrl=0.
  - occupancy=0, stall_cnt=0, in_ready=0.
- The first edge after rst rises: in_ready=1.
- Latency: a word accepted at edge N is presented with out_valid=1 from edge N+1.
- Throughput: one word per cycle, sustained, while out_ready=1.
- SKID=1: in_ready is driven directly from the sv flop, with no combinational path from out_ready. After out_ready drops, one more word can be absorbed; in_ready falls at the following edge.
- SKID=0: there is a combinational path from out_ready to in_ready.
- rst asserted mid-transfer: held words are lost immediately; there is no partial-cycle output.
- flush and bubble are sampled at the edge, same as in_valid.

## Test plan
- Stream, SKID=1: in_valid=1 with data 0x0001..0x0008, out_ready=1 throughout -> out_data 0x0001..0x0008 on consecutive cycles starting one cycle after the first accept; occupancy stays 1; stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> exactly one extra word is absorbed (occupancy=2, in_ready=0); stall_cnt=3; after release, order is preserved with no loss and no duplication.
- Bubble: bubble=1 on the word carrying in_ctrl=18'h3FFFF, data 0x1234 -> that word emerges with out_ctrl=0, out_data=0x1234.
- Flush with occupancy=2 and a concurrent in_valid -> next cycle out_valid=0, occupancy=0, out_data=0; the concurrent word never appears.
- Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Reset mid-stream: drop rst with occupancy=2 -> out_valid and in_ready go 0 immediately without waiting for an edge; after release, in_ready=1 one edge later.
